// File: rtl/seq_sreg_pkg.sv
// Shared definitions for the universal shift register: operation codes,
// FSM states and the operation-code width.
package seq_sreg_pkg;

  localparam int OP_W = 3;

  // Manual operation codes; code 7 is a second HOLD encoding.
  typedef enum logic [OP_W-1:0] {
    OP_HOLD  = 3'd0,
    OP_SHL   = 3'd1,
    OP_SHR   = 3'd2,
    OP_LOAD  = 3'd3,
    OP_ROL   = 3'd4,
    OP_ROR   = 3'd5,
    OP_CLR   = 3'd6,
    OP_HOLD7 = 3'd7
  } op_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/seq_sreg_bcnt.sv
// Loadable down-counter for the burst bit count. Saturates at zero so it
// can never wrap; exposes a zero flag and a "last step" flag (count == 1).
module seq_sreg_bcnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero,
  output logic             o_last
);

  logic [CNT_W-1:0] r_count;
  logic             w_zero;

  assign w_zero = (r_count == '0);
  assign o_zero = w_zero;
  assign o_last = (r_count == CNT_W'(1));

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for every register so all flops
    // update together from values sampled before the edge.
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && !w_zero) begin
      r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/seq_sreg_univ_param.sv
// Universal NBITS-bit shift register with manual operations and an
// automatic NBITS-bit left-shift burst.
// Optional feature: define SREG_ROTATE_EN to make op 4/5 rotate (ROL/ROR);
// otherwise those codes hold the register.
import seq_sreg_pkg::*;

module seq_sreg_univ_param #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [OP_W-1:0]  op,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [NBITS-1:0] pin,
  input  logic             burst,
  output logic [NBITS-1:0] pout,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam int               CNT_W    = $clog2(NBITS + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(NBITS);

  state_e           r_state;
  logic [NBITS-1:0] r_data;
  logic             r_busy;
  logic             r_done;
  logic [NBITS-1:0] w_manual_next;
  logic             w_cnt_load;
  logic             w_cnt_dec;
  logic             w_cnt_zero;
  logic             w_cnt_last;

  assign pout   = r_data;
  assign sout_l = r_data[NBITS-1];
  assign sout_r = r_data[0];
  assign busy   = r_busy;
  assign done   = r_done;

  assign w_cnt_load = (r_state == S_IDLE) && burst;
  assign w_cnt_dec  = (r_state == S_SHIFT);

  seq_sreg_bcnt #(
    .CNT_W (CNT_W)
  ) u_bcnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_cnt_load),
    .i_load_val (CNT_INIT),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero),
    .o_last     (w_cnt_last)
  );

  // Next register value for the manual operation selected by op.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal
    // unassigned, which would infer a latch.
    w_manual_next = r_data;
    case (op_e'(op))
      OP_SHL:  w_manual_next = {r_data[NBITS-2:0], sin_l};
      OP_SHR:  w_manual_next = {sin_r, r_data[NBITS-1:1]};
      OP_LOAD: w_manual_next = pin;
      OP_CLR:  w_manual_next = '0;
`ifdef SREG_ROTATE_EN
      OP_ROL:  w_manual_next = {r_data[NBITS-2:0], r_data[NBITS-1]};
      OP_ROR:  w_manual_next = {r_data[0], r_data[NBITS-1:1]};
`endif
      default: w_manual_next = r_data;
    endcase
  end

  // Burst FSM and datapath register with registered busy/done outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (burst) begin
            r_data  <= pin;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end else if (en) begin
            r_data <= w_manual_next;
          end
        end
        S_SHIFT: begin
          r_data <= {r_data[NBITS-2:0], sin_l};
          // The zero check only guards against an inconsistent counter;
          // the normal exit is the final decrement from one.
          if (w_cnt_last || w_cnt_zero) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_sreg_univ_param.sv
// Self-checking bench for seq_sreg_univ_param (NBITS=8). Expected outputs
// are pushed to a scoreboard as stimulus is driven and popped one cycle
// later when the register output is sampled, 1 time unit after the edge.
// Expectations for op 4/5 follow SREG_ROTATE_EN.
module tb_seq_sreg_univ_param;
  import seq_sreg_pkg::*;

`ifdef SREG_ROTATE_EN
  localparam bit ROT_ON = 1'b1;
`else
  localparam bit ROT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, en, sin_l, sin_r, burst;
  logic [2:0] op;
  logic [7:0] pin;
  logic [7:0] pout;
  logic       sout_l, sout_r, busy, done;

  always #5 clk = ~clk;

  seq_sreg_univ_param #(.NBITS(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .op     (op),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .pin    (pin),
    .burst  (burst),
    .pout   (pout),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .busy   (busy),
    .done   (done)
  );

  // Expected observation: {pout, sout_l, sout_r, busy, done}
  typedef struct {
    logic [11:0] v;
    string       name;
  } exp_t;

  typedef struct {
    logic       en;
    logic [2:0] op;
    logic [7:0] pin;
    logic       sl;
    logic       sr;
    logic [7:0] exp;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [11:0] exp_vec(input logic [7:0] p, input logic b, input logic d);
    return {p, p[7], p[0], b, d};
  endfunction

  function automatic logic [11:0] obs_vec();
    return {pout, sout_l, sout_r, busy, done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string nm, input logic [7:0] p, input logic b, input logic d);
    exp_t e;
    e.v    = exp_vec(p, b, d);
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t        e;
    logic [11:0] got;
    reset = 1'b1; en = 1'b1; op = OP_LOAD; pin = 8'hFF;
    sin_l = 1'b1; sin_r = 1'b1; burst = 1'b0;
    push("reset_load", 8'h00, 1'b0, 1'b0);
    tick(); tick();
    e = sb.pop_front(); got = obs_vec(); n_checks++;
    if (got !== e.v)
      $display("FAIL %s: got pout=%h sl/sr/busy/done=%b want pout=%h sl/sr/busy/done=%b",
               e.name, got[11:4], got[3:0], e.v[11:4], e.v[3:0]);
    else n_pass++;
    burst = 1'b1;
    push("reset_burst", 8'h00, 1'b0, 1'b0);
    tick();
    e = sb.pop_front(); got = obs_vec(); n_checks++;
    if (got !== e.v)
      $display("FAIL %s: got pout=%h sl/sr/busy/done=%b want pout=%h sl/sr/busy/done=%b",
               e.name, got[11:4], got[3:0], e.v[11:4], e.v[3:0]);
    else n_pass++;
    reset = 1'b0; burst = 1'b0; en = 1'b0;
  endtask

  task automatic test_manual_ops();
    vec_t        tbl[$];
    vec_t        t;
    exp_t        e;
    logic [11:0] got;
    tbl.push_back('{1'b1, OP_LOAD, 8'h3C, 1'b0, 1'b0, 8'h3C});
    tbl.push_back('{1'b1, OP_SHL,  8'h00, 1'b1, 1'b0, 8'h79});
    tbl.push_back('{1'b1, OP_SHR,  8'h00, 1'b0, 1'b1, 8'hBC});
    tbl.push_back('{1'b0, OP_CLR,  8'h00, 1'b0, 1'b0, 8'hBC});
    tbl.push_back('{1'b1, OP_HOLD, 8'h55, 1'b1, 1'b1, 8'hBC});
    tbl.push_back('{1'b1, 3'd7,    8'h55, 1'b1, 1'b1, 8'hBC});
    tbl.push_back('{1'b1, OP_CLR,  8'h55, 1'b1, 1'b1, 8'h00});
    tbl.push_back('{1'b1, OP_LOAD, 8'h81, 1'b0, 1'b0, 8'h81});
    tbl.push_back('{1'b1, OP_SHR,  8'h00, 1'b1, 1'b0, 8'h40});
    tbl.push_back('{1'b1, OP_ROR,  8'h00, 1'b1, 1'b1, ROT_ON ? 8'h20 : 8'h40});
    tbl.push_back('{1'b1, OP_LOAD, 8'h81, 1'b0, 1'b0, 8'h81});
    tbl.push_back('{1'b1, OP_ROR,  8'h00, 1'b0, 1'b0, ROT_ON ? 8'hC0 : 8'h81});
    tbl.push_back('{1'b1, OP_LOAD, 8'h81, 1'b0, 1'b0, 8'h81});
    tbl.push_back('{1'b1, OP_ROL,  8'h00, 1'b0, 1'b0, ROT_ON ? 8'h03 : 8'h81});
    tbl.push_back('{1'b1, OP_SHL,  8'h00, 1'b0, 1'b1, ROT_ON ? 8'h06 : 8'h02});
    foreach (tbl[i]) begin
      t = tbl[i];
      en = t.en; op = t.op; pin = t.pin; sin_l = t.sl; sin_r = t.sr;
      push($sformatf("manual_%0d", i), t.exp, 1'b0, 1'b0);
      tick();
      e = sb.pop_front(); got = obs_vec(); n_checks++;
      if (got !== e.v)
        $display("FAIL %s: got pout=%h sl/sr/busy/done=%b want pout=%h sl/sr/busy/done=%b",
                 e.name, got[11:4], got[3:0], e.v[11:4], e.v[3:0]);
      else n_pass++;
    end
    en = 1'b0;
  endtask

  // Runs one burst starting now; returns after sampling the done cycle.
  // en=1/op=CLR and a stray burst pulse are applied during SHIFT and must
  // have no effect.
  task automatic burst_seq(input string nm, input logic [7:0] p, input logic s);
    logic [7:0]  m;
    exp_t        e;
    logic [11:0] got;
    m = p;
    burst = 1'b1; pin = p; sin_l = s; en = 1'b1; op = OP_CLR;
    for (int k = 1; k <= 9; k++) begin
      if (k == 9) push($sformatf("%s_c%0d", nm, k), m, 1'b0, 1'b1);
      else        push($sformatf("%s_c%0d", nm, k), m, 1'b1, 1'b0);
      tick();
      e = sb.pop_front(); got = obs_vec(); n_checks++;
      if (got !== e.v)
        $display("FAIL %s: got pout=%h sl/sr/busy/done=%b want pout=%h sl/sr/busy/done=%b",
                 e.name, got[11:4], got[3:0], e.v[11:4], e.v[3:0]);
      else n_pass++;
      burst = (k == 3);
      pin   = ~p;
      m     = {m[6:0], s};
    end
    burst = 1'b0;
  endtask

  task automatic idle_check(input string nm, input logic [7:0] p);
    exp_t        e;
    logic [11:0] got;
    en = 1'b0; burst = 1'b0;
    push(nm, p, 1'b0, 1'b0);
    tick();
    e = sb.pop_front(); got = obs_vec(); n_checks++;
    if (got !== e.v)
      $display("FAIL %s: got pout=%h sl/sr/busy/done=%b want pout=%h sl/sr/busy/done=%b",
               e.name, got[11:4], got[3:0], e.v[11:4], e.v[3:0]);
    else n_pass++;
  endtask

  task automatic test_burst();
    burst_seq("burstA5", 8'hA5, 1'b0);
    idle_check("burstA5_after", 8'h00);
  endtask

  task automatic test_back_to_back();
    burst_seq("b2b_first", 8'h5A, 1'b1);
    burst_seq("b2b_second", 8'hC3, 1'b0);
    idle_check("b2b_after", 8'h00);
  endtask

  task automatic test_reset_abort();
    logic [7:0]  m;
    exp_t        e;
    logic [11:0] got;
    m = 8'hA5;
    burst = 1'b1; pin = 8'hA5; sin_l = 1'b1; en = 1'b0; op = OP_HOLD;
    for (int k = 1; k <= 4; k++) begin
      push($sformatf("abort_c%0d", k), m, 1'b1, 1'b0);
      tick();
      e = sb.pop_front(); got = obs_vec(); n_checks++;
      if (got !== e.v)
        $display("FAIL %s: got pout=%h sl/sr/busy/done=%b want pout=%h sl/sr/busy/done=%b",
                 e.name, got[11:4], got[3:0], e.v[11:4], e.v[3:0]);
      else n_pass++;
      burst = 1'b0;
      m = {m[6:0], 1'b1};
    end
    reset = 1'b1;
    for (int k = 5; k <= 16; k++) begin
      push($sformatf("abort_c%0d", k), 8'h00, 1'b0, 1'b0);
      tick();
      reset = 1'b0;
      e = sb.pop_front(); got = obs_vec(); n_checks++;
      if (got !== e.v)
        $display("FAIL %s: got pout=%h sl/sr/busy/done=%b want pout=%h sl/sr/busy/done=%b",
                 e.name, got[11:4], got[3:0], e.v[11:4], e.v[3:0]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_manual_ops();
    test_burst();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
